ex_stage_md: RTL and testbench
==============================

Name: ex_stage_md

Overview:
- Parametrised next-generation execute stage: combinational ALU plus an iterative unsigned multiply/divide unit, feeding the EX/MEM pipeline register.
- Sits between ID and MEM.
- Adds the following over the single-cycle stage:
  - a multi-cycle MUL/DIVU/REMU path with a stall request (md_busy);
  - width generics;
  - overflow-exception insertion into the EX/MEM register.

Parameters:
- DATA_W, 32, datapath/operand/result width.
- PC_W, 30, word-address PC width.
- REG_ADDR_W, 5, destination register address width.
- OVF_EXP_CODE, 3'd4, exception code written on signed-arithmetic overflow.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous active-low reset.
- id_alu_in_0  in  DATA_W  operand 0.
- id_alu_in_1  in  DATA_W  operand 1.
- id_alu_op  in  4  ALU opcode:
  - 0 pass in_0, 1 AND, 2 OR, 3 XOR, 4 ADDS, 5 ADDU;
  - 6 SUBS, 7 SUBU, 8 SHRL, 9 SHLL (shift amount = in_1[log2(DATA_W)-1:0]);
  - others give 0.
- id_md_op  in  2  00 none (ALU), 01 MUL low word, 10 DIVU quotient, 11 REMU remainder.
- id_pc  in  PC_W  ID/EX PC.
- id_en  in  1  ID/EX valid.
- id_br_flag  in  1  branch flag.
- id_mem_op  in  2  memory op.
- id_mem_wr_data  in  DATA_W  store data.
- id_ctrl_op  in  2  control op.
- id_dst_addr  in  REG_ADDR_W  destination register.
- id_gpr_we_  in  1  register write enable, active-low.
- id_exp_code  in  3  incoming exception code.
- stall  in  1  external pipeline stall.
- flush  in  1  pipeline flush.
- int_detect  in  1  interrupt/exception flush.
- fwd_data  out  DATA_W  forwarding data:
  - ALU result when id_md_op==0;
  - MD result when in DONE;
  - 0 otherwise.
- md_busy  out  1  stall request to upstream stages.
- ex_pc, ex_en, ex_br_flag, ex_mem_op, ex_mem_wr_data, ex_ctrl_op, ex_dst_addr, ex_gpr_we_, ex_exp_code  out  (widths as id_*)  EX/MEM register.
- ex_out  out  DATA_W  registered ALU/MD result.

Behaviour:
- Reset (reset==0, asynchronous):
  - all ex_* are 0 except ex_gpr_we_=1;
  - ex_out=0;
  - MD FSM in IDLE, md_busy=0, internal MD registers 0.
- ALU:
  - Combinational; arithmetic is modulo 2^DATA_W.
  - Overflow flag (of) is asserted only for ADDS/SUBS on signed-operand sign mismatch.
- MD FSM states: IDLE, RUN, DONE.
  - start = id_en & (id_md_op!=0) & ~flush & ~int_detect.
  - IDLE: on start, latch operands and op, clear counter, go to RUN.
  - RUN: one shift-add (MUL) or restoring shift-subtract (DIV/REM) step per cycle. After DATA_W steps (counter==DATA_W-1), go to DONE.
  - DONE: result held. Return to IDLE on the first cycle with stall==0, which is the cycle the EX register captures it.
  - md_busy = (IDLE & start) | RUN. It is combinational, so upstream freezes in the issue cycle.
  - Latency: result is captured into EX/MEM DATA_W+1 cycles after the issue cycle when there is no stall.
  - Divide by zero: quotient = all ones, remainder = dividend. No exception.
  - flush or int_detect in any state forces IDLE next cycle and discards the result.
  - A new start is not accepted while in RUN or DONE.
- EX/MEM register update priority per clock edge:
  1. int_detect or flush: insert bubble. ex_en=0, ex_gpr_we_=1; ex_mem_op, ex_ctrl_op, ex_br_flag, ex_exp_code, ex_out, ex_pc, ex_dst_addr, ex_mem_wr_data = 0.
  2. stall: hold all values.
  3. md_busy: insert bubble (same values as 1), so MEM does not re-execute the previous instruction.
  4. Otherwise load all id_* fields. ex_out = MD result if in DONE, else ALU result.
- Overflow on load (id_en & of & id_alu_op in {ADDS,SUBS}): ex_exp_code=OVF_EXP_CODE and ex_gpr_we_=1, suppressing the write. All other fields load normally.
- A nonzero incoming id_exp_code takes precedence over overflow.
- reset asserted mid-RUN: immediate return to IDLE; outputs take reset values.

Test Plan:
- Reset released, no activity -> all ex_* zero, ex_gpr_we_=1, md_busy=0.
- ADDU 0xFFFFFFFF+1, id_en=1 -> next edge ex_out=0, ex_exp_code=0. ADDS 0x7FFFFFFF+1 -> ex_exp_code=4, ex_gpr_we_=1.
- MUL 7*6 issued -> md_busy high for 33 cycles (DATA_W=32), ex_en=0 meanwhile. Captured ex_out=42 with ex_en=1 exactly 33 cycles after issue.
- DIVU 100/7 -> ex_out=14. REMU 100/7 -> ex_out=2. DIVU 5/0 -> 0xFFFFFFFF. REMU 5/0 -> 5.
- flush asserted mid-RUN (cycle 10) -> next cycle IDLE, md_busy=0, ex_en=0, no MD result is ever written.
- stall held 3 cycles while in DONE -> ex_* held unchanged. Result loads on the first stall==0 edge and the FSM returns to IDLE.

Source files
------------

// File: rtl/ex_stage_md.sv
`default_nettype none
// ============================================================================
// Module   : ex_stage_md
// Purpose  : Execute stage. A combinational ALU and an iterative unsigned
//            multiply/divide unit (MUL low word, DIVU, REMU) feed the EX/MEM
//            pipeline register. A signed add/sub overflow loads an exception
//            code into EX/MEM.
// Ports    : clk, reset (async, active-low)
//            id_*        ID/EX operands, opcodes and pass-through fields
//            stall       hold the EX/MEM register
//            flush       squash: insert a bubble and abort any MD operation
//            int_detect  same effect as flush, for interrupts/exceptions
//            fwd_data    forwarding value for the instruction now in EX
//            md_busy     stall request while an MD operation is issued or
//                        running
//            ex_*        EX/MEM register, ex_out is the result
// Revision : 1.0 - initial release
// ============================================================================
module ex_stage_md #(
   parameter int         DATA_W       = 32,
   parameter int         PC_W         = 30,
   parameter int         REG_ADDR_W   = 5,
   parameter logic [2:0] OVF_EXP_CODE = 3'd4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_W-1:0]     id_alu_in_0,
   input  logic [DATA_W-1:0]     id_alu_in_1,
   input  logic [3:0]            id_alu_op,
   input  logic [1:0]            id_md_op,
   input  logic [PC_W-1:0]       id_pc,
   input  logic                  id_en,
   input  logic                  id_br_flag,
   input  logic [1:0]            id_mem_op,
   input  logic [DATA_W-1:0]     id_mem_wr_data,
   input  logic [1:0]            id_ctrl_op,
   input  logic [REG_ADDR_W-1:0] id_dst_addr,
   input  logic                  id_gpr_we_,
   input  logic [2:0]            id_exp_code,
   input  logic                  stall,
   input  logic                  flush,
   input  logic                  int_detect,
   output logic [DATA_W-1:0]     fwd_data,
   output logic                  md_busy,
   output logic [PC_W-1:0]       ex_pc,
   output logic                  ex_en,
   output logic                  ex_br_flag,
   output logic [1:0]            ex_mem_op,
   output logic [DATA_W-1:0]     ex_mem_wr_data,
   output logic [1:0]            ex_ctrl_op,
   output logic [REG_ADDR_W-1:0] ex_dst_addr,
   output logic                  ex_gpr_we_,
   output logic [2:0]            ex_exp_code,
   output logic [DATA_W-1:0]     ex_out
);

   localparam int c_SH_W  = $clog2(DATA_W);
   localparam int c_CNT_W = $clog2(DATA_W);
   localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DATA_W - 1);

   localparam logic [3:0] c_ALU_PASS = 4'd0;
   localparam logic [3:0] c_ALU_AND  = 4'd1;
   localparam logic [3:0] c_ALU_OR   = 4'd2;
   localparam logic [3:0] c_ALU_XOR  = 4'd3;
   localparam logic [3:0] c_ALU_ADDS = 4'd4;
   localparam logic [3:0] c_ALU_ADDU = 4'd5;
   localparam logic [3:0] c_ALU_SUBS = 4'd6;
   localparam logic [3:0] c_ALU_SUBU = 4'd7;
   localparam logic [3:0] c_ALU_SHRL = 4'd8;
   localparam logic [3:0] c_ALU_SHLL = 4'd9;

   localparam logic [1:0] c_MD_NONE = 2'd0;
   localparam logic [1:0] c_MD_MUL  = 2'd1;
   localparam logic [1:0] c_MD_REMU = 2'd3;

   localparam logic [1:0] c_ST_IDLE = 2'd0;
   localparam logic [1:0] c_ST_RUN  = 2'd1;
   localparam logic [1:0] c_ST_DONE = 2'd2;

   // ------------------------------------------------------------------------
   // ALU
   // ------------------------------------------------------------------------
   logic [DATA_W-1:0] w_sum;
   logic [DATA_W-1:0] w_diff;
   logic [c_SH_W-1:0] w_shamt;
   logic [DATA_W-1:0] w_alu_out;
   logic              w_of;

   assign w_sum   = id_alu_in_0 + id_alu_in_1;
   assign w_diff  = id_alu_in_0 - id_alu_in_1;
   assign w_shamt = id_alu_in_1[c_SH_W-1:0];

   always_comb begin
      w_alu_out = '0;
      w_of      = 1'b0;
      case (id_alu_op)
         c_ALU_PASS: w_alu_out = id_alu_in_0;
         c_ALU_AND:  w_alu_out = id_alu_in_0 & id_alu_in_1;
         c_ALU_OR:   w_alu_out = id_alu_in_0 | id_alu_in_1;
         c_ALU_XOR:  w_alu_out = id_alu_in_0 ^ id_alu_in_1;
         c_ALU_ADDS: begin
            w_alu_out = w_sum;
            // like-signed operands producing a result of the other sign
            w_of = (id_alu_in_0[DATA_W-1] == id_alu_in_1[DATA_W-1]) &&
                   (w_sum[DATA_W-1] != id_alu_in_0[DATA_W-1]);
         end
         c_ALU_ADDU: w_alu_out = w_sum;
         c_ALU_SUBS: begin
            w_alu_out = w_diff;
            // differently-signed operands, result sign differs from in_0
            w_of = (id_alu_in_0[DATA_W-1] != id_alu_in_1[DATA_W-1]) &&
                   (w_diff[DATA_W-1] != id_alu_in_0[DATA_W-1]);
         end
         c_ALU_SUBU: w_alu_out = w_diff;
         c_ALU_SHRL: w_alu_out = id_alu_in_0 >> w_shamt;
         c_ALU_SHLL: w_alu_out = id_alu_in_0 << w_shamt;
         default:    w_alu_out = '0;
      endcase
   end

   // ------------------------------------------------------------------------
   // Multiply/divide FSM
   // ------------------------------------------------------------------------
   logic [1:0]         r_state;
   logic [1:0]         w_state_nxt;
   logic               w_start;
   logic               w_md_done;
   logic [1:0]         r_md_op;
   logic [DATA_W-1:0]  r_md_a;    // MUL: multiplicand, DIV: divisor
   logic [DATA_W-1:0]  r_md_b;    // MUL: multiplier, DIV: dividend -> quotient
   logic [DATA_W-1:0]  r_md_acc;  // MUL: product, DIV: partial remainder
   logic [c_CNT_W-1:0] r_cnt;

   assign w_start = id_en & (id_md_op != c_MD_NONE) & ~flush & ~int_detect;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= c_ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (flush || int_detect) begin
         w_state_nxt = c_ST_IDLE;
      end else begin
         case (r_state)
            c_ST_IDLE: if (w_start)            w_state_nxt = c_ST_RUN;
            c_ST_RUN:  if (r_cnt == c_CNT_LAST) w_state_nxt = c_ST_DONE;
            c_ST_DONE: if (!stall)              w_state_nxt = c_ST_IDLE;
            default:                            w_state_nxt = c_ST_IDLE;
         endcase
      end
   end

   // md_busy is combinational so upstream freezes already in the issue cycle
   always_comb begin
      md_busy   = ((r_state == c_ST_IDLE) && w_start) || (r_state == c_ST_RUN);
      w_md_done = (r_state == c_ST_DONE);
   end

   // Iteration step values
   logic [DATA_W-1:0] w_mul_acc_nxt;
   logic [DATA_W:0]   w_rem_sh;
   logic [DATA_W:0]   w_rem_sub;
   logic              w_div_ok;
   logic [DATA_W-1:0] w_md_res;

   assign w_mul_acc_nxt = r_md_b[0] ? (r_md_acc + r_md_a) : r_md_acc;
   // Restoring division: shift the next dividend bit into the remainder and
   // subtract the divisor if it fits. A zero divisor always "fits", which
   // naturally yields quotient all-ones and remainder equal to the dividend.
   assign w_rem_sh  = {r_md_acc, r_md_b[DATA_W-1]};
   assign w_rem_sub = w_rem_sh - {1'b0, r_md_a};
   assign w_div_ok  = ~w_rem_sub[DATA_W];
   assign w_md_res  = ((r_md_op == c_MD_MUL) || (r_md_op == c_MD_REMU)) ?
                      r_md_acc : r_md_b;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_md_op  <= '0;
         r_md_a   <= '0;
         r_md_b   <= '0;
         r_md_acc <= '0;
         r_cnt    <= '0;
      end else if ((r_state == c_ST_IDLE) && w_start) begin
         r_md_op  <= id_md_op;
         r_md_acc <= '0;
         r_cnt    <= '0;
         if (id_md_op == c_MD_MUL) begin
            r_md_a <= id_alu_in_0;
            r_md_b <= id_alu_in_1;
         end else begin
            r_md_a <= id_alu_in_1;
            r_md_b <= id_alu_in_0;
         end
      end else if (r_state == c_ST_RUN) begin
         r_cnt <= r_cnt + 1'b1;
         if (r_md_op == c_MD_MUL) begin
            r_md_acc <= w_mul_acc_nxt;
            r_md_a   <= r_md_a << 1;
            r_md_b   <= r_md_b >> 1;
         end else if (w_div_ok) begin
            r_md_acc <= w_rem_sub[DATA_W-1:0];
            r_md_b   <= {r_md_b[DATA_W-2:0], 1'b1};
         end else begin
            r_md_acc <= w_rem_sh[DATA_W-1:0];
            r_md_b   <= {r_md_b[DATA_W-2:0], 1'b0};
         end
      end
   end

   always_comb begin
      fwd_data = '0;
      if (id_md_op == c_MD_NONE) begin
         fwd_data = w_alu_out;
      end else if (w_md_done) begin
         fwd_data = w_md_res;
      end
   end

   // ------------------------------------------------------------------------
   // EX/MEM register
   // ------------------------------------------------------------------------
   logic w_ovf;
   logic w_bubble;

   // w_of is only ever set for ADDS/SUBS
   assign w_ovf = id_en & w_of;
   // A flush beats a stall; md_busy only bubbles when not stalled, so MEM
   // never sees the previous instruction twice.
   assign w_bubble = flush | int_detect | (~stall & md_busy);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ex_pc          <= '0;
         ex_en          <= 1'b0;
         ex_br_flag     <= 1'b0;
         ex_mem_op      <= '0;
         ex_mem_wr_data <= '0;
         ex_ctrl_op     <= '0;
         ex_dst_addr    <= '0;
         ex_gpr_we_     <= 1'b1;
         ex_exp_code    <= '0;
         ex_out         <= '0;
      end else if (w_bubble) begin
         ex_pc          <= '0;
         ex_en          <= 1'b0;
         ex_br_flag     <= 1'b0;
         ex_mem_op      <= '0;
         ex_mem_wr_data <= '0;
         ex_ctrl_op     <= '0;
         ex_dst_addr    <= '0;
         ex_gpr_we_     <= 1'b1;
         ex_exp_code    <= '0;
         ex_out         <= '0;
      end else if (!stall) begin
         ex_pc          <= id_pc;
         ex_en          <= id_en;
         ex_br_flag     <= id_br_flag;
         ex_mem_op      <= id_mem_op;
         ex_mem_wr_data <= id_mem_wr_data;
         ex_ctrl_op     <= id_ctrl_op;
         ex_dst_addr    <= id_dst_addr;
         ex_out         <= w_md_done ? w_md_res : w_alu_out;
         // an incoming exception outranks overflow
         if (id_exp_code != 3'd0) begin
            ex_exp_code <= id_exp_code;
            ex_gpr_we_  <= id_gpr_we_;
         end else if (w_ovf) begin
            ex_exp_code <= OVF_EXP_CODE;
            ex_gpr_we_  <= 1'b1;
         end else begin
            ex_exp_code <= 3'd0;
            ex_gpr_we_  <= id_gpr_we_;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ex_stage_md.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_stage_md
// Purpose  : Self-checking bench for ex_stage_md. Expected EX/MEM contents
//            are queued when an instruction is issued and compared by a
//            monitor whenever a freshly loaded valid entry appears.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_stage_md;

   localparam int DATA_W = 32;
   localparam int PC_W   = 30;
   localparam int RA_W   = 5;

   logic              clk = 1'b0;
   logic              reset;
   logic [DATA_W-1:0] id_alu_in_0, id_alu_in_1, id_mem_wr_data;
   logic [3:0]        id_alu_op;
   logic [1:0]        id_md_op, id_mem_op, id_ctrl_op;
   logic [PC_W-1:0]   id_pc;
   logic              id_en, id_br_flag, id_gpr_we_;
   logic [RA_W-1:0]   id_dst_addr;
   logic [2:0]        id_exp_code;
   logic              stall, flush, int_detect;
   logic [DATA_W-1:0] fwd_data, ex_mem_wr_data, ex_out;
   logic              md_busy, ex_en, ex_br_flag, ex_gpr_we_;
   logic [PC_W-1:0]   ex_pc;
   logic [1:0]        ex_mem_op, ex_ctrl_op;
   logic [RA_W-1:0]   ex_dst_addr;
   logic [2:0]        ex_exp_code;

   always #5 clk = ~clk;

   ex_stage_md #(
      .DATA_W(DATA_W), .PC_W(PC_W), .REG_ADDR_W(RA_W), .OVF_EXP_CODE(3'd4)
   ) dut (
      .clk(clk), .reset(reset),
      .id_alu_in_0(id_alu_in_0), .id_alu_in_1(id_alu_in_1),
      .id_alu_op(id_alu_op), .id_md_op(id_md_op), .id_pc(id_pc),
      .id_en(id_en), .id_br_flag(id_br_flag), .id_mem_op(id_mem_op),
      .id_mem_wr_data(id_mem_wr_data), .id_ctrl_op(id_ctrl_op),
      .id_dst_addr(id_dst_addr), .id_gpr_we_(id_gpr_we_),
      .id_exp_code(id_exp_code), .stall(stall), .flush(flush),
      .int_detect(int_detect), .fwd_data(fwd_data), .md_busy(md_busy),
      .ex_pc(ex_pc), .ex_en(ex_en), .ex_br_flag(ex_br_flag),
      .ex_mem_op(ex_mem_op), .ex_mem_wr_data(ex_mem_wr_data),
      .ex_ctrl_op(ex_ctrl_op), .ex_dst_addr(ex_dst_addr),
      .ex_gpr_we_(ex_gpr_we_), .ex_exp_code(ex_exp_code), .ex_out(ex_out)
   );

   typedef struct packed {
      logic [PC_W-1:0]   pc;
      logic              en;
      logic              br;
      logic [1:0]        mem_op;
      logic [DATA_W-1:0] wr;
      logic [1:0]        ctrl;
      logic [RA_W-1:0]   dst;
      logic              we_;
      logic [2:0]        exp;
      logic [DATA_W-1:0] out;
   } ex_t;

   ex_t sb_q[$];
   int  checks = 0;
   int  errors = 0;
   bit  last_stall = 1'b0;
   ex_t mon_a, mon_e;

   function automatic ex_t dut_ex();
      ex_t a;
      a.pc = ex_pc; a.en = ex_en; a.br = ex_br_flag; a.mem_op = ex_mem_op;
      a.wr = ex_mem_wr_data; a.ctrl = ex_ctrl_op; a.dst = ex_dst_addr;
      a.we_ = ex_gpr_we_; a.exp = ex_exp_code; a.out = ex_out;
      return a;
   endfunction

   function automatic ex_t bubble_ex();
      ex_t e = '0;
      e.we_ = 1'b1;
      return e;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic chk_ex(input string name, input ex_t act, input ex_t req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   // Reference ALU: plain arithmetic, overflow judged on true signed sums
   function automatic void alu_ref(input logic [3:0] op, input logic [31:0] a,
                                   input logic [31:0] b, output logic [31:0] r,
                                   output bit ovf);
      longint s;
      logic [4:0] sh;
      sh  = b[4:0];
      ovf = 1'b0;
      r   = '0;
      case (op)
         4'd0: r = a;
         4'd1: r = a & b;
         4'd2: r = a | b;
         4'd3: r = a ^ b;
         4'd4: begin
            r = a + b;
            s = longint'($signed(a)) + longint'($signed(b));
            ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         end
         4'd5: r = a + b;
         4'd6: begin
            r = a - b;
            s = longint'($signed(a)) - longint'($signed(b));
            ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         end
         4'd7: r = a - b;
         4'd8: r = a >> sh;
         4'd9: r = a << sh;
         default: r = '0;
      endcase
   endfunction

   function automatic logic [31:0] md_ref(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
      longint unsigned p;
      p = longint'(a) * longint'(b);
      case (op)
         2'd1:    return p[31:0];
         2'd2:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
         2'd3:    return (b == 0) ? a : a % b;
         default: return 32'h0;
      endcase
   endfunction

   // Expected EX/MEM entry for the instruction currently driven on id_*
   function automatic ex_t expect_load(input logic [31:0] res, input bit ovf);
      ex_t e;
      e.pc = id_pc; e.en = id_en; e.br = id_br_flag; e.mem_op = id_mem_op;
      e.wr = id_mem_wr_data; e.ctrl = id_ctrl_op; e.dst = id_dst_addr;
      e.out = res;
      if (id_exp_code != 0) begin
         e.exp = id_exp_code; e.we_ = id_gpr_we_;
      end else if (ovf) begin
         e.exp = 3'd4; e.we_ = 1'b1;
      end else begin
         e.exp = 3'd0; e.we_ = id_gpr_we_;
      end
      return e;
   endfunction

   // Monitor: a valid entry loaded at the last edge (not a stall hold)
   always @(posedge clk) last_stall <= stall;

   always @(negedge clk) begin
      if (reset === 1'b1 && ex_en === 1'b1 && !last_stall) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected: got valid entry %h, required no entry", dut_ex());
         end else begin
            mon_e = sb_q.pop_front();
            mon_a = dut_ex();
            checks++;
            if (mon_a !== mon_e) begin
               errors++;
               $display("FAIL sb_compare: got %h, required %h", mon_a, mon_e);
            end
         end
      end
   end

   task automatic set_idle();
      id_en = 0; id_md_op = 0; id_alu_op = 0; id_alu_in_0 = 0; id_alu_in_1 = 0;
      id_pc = 0; id_br_flag = 0; id_mem_op = 0; id_mem_wr_data = 0;
      id_ctrl_op = 0; id_dst_addr = 0; id_gpr_we_ = 1; id_exp_code = 0;
      stall = 0; flush = 0; int_detect = 0;
   endtask

   task automatic rand_side();
      id_pc = PC_W'($urandom); id_br_flag = 1'($urandom);
      id_mem_op = 2'($urandom); id_mem_wr_data = $urandom;
      id_ctrl_op = 2'($urandom); id_dst_addr = RA_W'($urandom);
      id_gpr_we_ = 1'($urandom);
   endtask

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 5))
         0: return 32'h7FFF_FFFF;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return 32'($urandom_range(0, 40));
         default: return $urandom;
      endcase
   endfunction

   task automatic directed_alu(input string name, input logic [3:0] op,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [2:0] exp_in, input logic we_in,
                               input logic [31:0] want_out, input logic [2:0] want_exp,
                               input logic want_we);
      logic [31:0] r;
      bit ovf;
      @(posedge clk); #1;
      set_idle();
      rand_side();
      id_en = 1; id_alu_op = op; id_alu_in_0 = a; id_alu_in_1 = b;
      id_exp_code = exp_in; id_gpr_we_ = we_in;
      alu_ref(op, a, b, r, ovf);
      sb_q.push_back(expect_load(r, ovf));
      @(posedge clk); #1;
      chk({name, "_out"}, 64'(ex_out), 64'(want_out));
      chk({name, "_exp"}, 64'(ex_exp_code), 64'(want_exp));
      chk({name, "_we"}, 64'(ex_gpr_we_), 64'(want_we));
      set_idle();
   endtask

   task automatic rand_alu_cycle();
      logic [31:0] r;
      bit ovf;
      @(posedge clk); #1;
      rand_side();
      id_en       = ($urandom_range(0, 9) < 8);
      id_md_op    = 0;
      id_alu_op   = 4'($urandom_range(0, 11));
      id_alu_in_0 = pick_operand();
      id_alu_in_1 = pick_operand();
      id_exp_code = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      stall       = ($urandom_range(0, 9) == 0);
      flush       = ($urandom_range(0, 19) == 0);
      int_detect  = ($urandom_range(0, 29) == 0);
      alu_ref(id_alu_op, id_alu_in_0, id_alu_in_1, r, ovf);
      if (id_en && !stall && !flush && !int_detect)
         sb_q.push_back(expect_load(r, ovf));
      #1;
      chk("fwd_alu", 64'(fwd_data), 64'(r));
   endtask

   task automatic issue_md(input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] want,
                           input int nstall);
      int  busy_n;
      int  guard;
      bit  saw_en;
      @(posedge clk); #1;
      set_idle();
      rand_side();
      id_en = 1; id_md_op = op; id_alu_op = 0; id_alu_in_0 = a; id_alu_in_1 = b;
      sb_q.push_back(expect_load(want, 1'b0));
      busy_n = 0; guard = 0; saw_en = 0;
      @(negedge clk);
      while (md_busy && guard < 200) begin
         busy_n++;
         if (ex_en) saw_en = 1;
         guard++;
         @(negedge clk);
      end
      chk("md_busy_cycles", 64'(busy_n), 64'(DATA_W + 1));
      chk("md_ex_en_while_busy", 64'(saw_en), 64'd0);
      chk("md_fwd_done", 64'(fwd_data), 64'(want));
      if (nstall > 0) begin
         stall = 1;
         repeat (nstall) begin
            @(negedge clk);
            chk_ex("stall_hold", dut_ex(), bubble_ex());
            chk("stall_busy", 64'(md_busy), 64'd0);
         end
         stall = 0;
      end
      @(posedge clk); #1;
      chk("md_capture_en", 64'(ex_en), 64'd1);
      chk("md_capture_out", 64'(ex_out), 64'(want));
      set_idle();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "timeout");
   end

   initial begin
      int  saw;
      logic [1:0]  op;
      logic [31:0] a, b;
      set_idle();
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_ex("reset_ex", dut_ex(), bubble_ex());
      chk("reset_busy", 64'(md_busy), 64'd0);
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk_ex("idle_ex", dut_ex(), bubble_ex());
      chk("idle_busy", 64'(md_busy), 64'd0);

      directed_alu("addu_wrap", 4'd5, 32'hFFFF_FFFF, 32'h1, 3'd0, 1'b0, 32'h0, 3'd0, 1'b0);
      directed_alu("adds_ovf", 4'd4, 32'h7FFF_FFFF, 32'h1, 3'd0, 1'b0, 32'h8000_0000, 3'd4, 1'b1);
      directed_alu("subs_ovf", 4'd6, 32'h8000_0000, 32'h1, 3'd0, 1'b0, 32'h7FFF_FFFF, 3'd4, 1'b1);
      directed_alu("exp_prio", 4'd4, 32'h7FFF_FFFF, 32'h1, 3'd2, 1'b0, 32'h8000_0000, 3'd2, 1'b0);
      directed_alu("shll", 4'd9, 32'h0000_0003, 32'h0000_0024, 3'd0, 1'b0, 32'h30, 3'd0, 1'b0);

      repeat (250) rand_alu_cycle();
      @(posedge clk); #1;
      set_idle();
      @(posedge clk);

      issue_md(2'd1, 32'd7, 32'd6, 32'd42, 0);
      issue_md(2'd2, 32'd100, 32'd7, 32'd14, 0);
      issue_md(2'd3, 32'd100, 32'd7, 32'd2, 0);
      issue_md(2'd2, 32'd5, 32'd0, 32'hFFFF_FFFF, 0);
      issue_md(2'd3, 32'd5, 32'd0, 32'd5, 0);
      issue_md(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 3);
      for (int i = 0; i < 6; i++) begin
         op = 2'($urandom_range(1, 3));
         a  = $urandom;
         b  = ($urandom_range(0, 3) == 0) ? 32'd0 :
              ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(1, 50));
         issue_md(op, a, b, md_ref(op, a, b), $urandom_range(0, 2));
      end

      // flush mid-RUN: no result may ever be written
      @(posedge clk); #1;
      set_idle();
      id_en = 1; id_md_op = 2'd1; id_alu_in_0 = 32'd7; id_alu_in_1 = 32'd6;
      repeat (10) @(negedge clk);
      flush = 1;
      @(posedge clk); #1;
      set_idle();
      #1;
      chk("flush_busy", 64'(md_busy), 64'd0);
      chk("flush_ex_en", 64'(ex_en), 64'd0);
      saw = 0;
      repeat (40) begin
         @(negedge clk);
         if (ex_en || md_busy) saw = 1;
      end
      chk("flush_no_result", 64'(saw), 64'd0);

      // asynchronous reset during RUN
      @(posedge clk); #1;
      id_en = 1; id_md_op = 2'd2; id_alu_in_0 = 32'd1000; id_alu_in_1 = 32'd3;
      repeat (5) @(negedge clk);
      reset = 1'b0;
      set_idle();
      #1;
      chk("rst_run_busy", 64'(md_busy), 64'd0);
      chk_ex("rst_run_ex", dut_ex(), bubble_ex());
      @(negedge clk);
      reset = 1'b1;
      repeat (40) @(posedge clk);
      #1;
      chk_ex("post_rst_ex", dut_ex(), bubble_ex());
      chk("post_rst_busy", 64'(md_busy), 64'd0);

      // after reset the unit must accept a new operation normally
      issue_md(2'd2, 32'd1000, 32'd3, 32'd333, 0);

      repeat (3) @(posedge clk);
      chk("sb_drained", 64'(sb_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
